// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: per-digit code/blank storage, IDLE/GUARD/ON
// scan FSM, registered anode selects, decoder code and frame wrap pulse.
module seg_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000,
    parameter int GUARD    = 4,
    localparam int AW      = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [3:0]          wr_data,
    input  logic                wr_blank,
    output logic [3:0]          code_out,
    output logic [N_DIGITS-1:0] dig_an,
    output logic [AW-1:0]       scan_idx,
    output logic                frame_tick
);

    localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_ON
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [AW-1:0]       idx_nxt;
    logic                tick_nxt;
    logic [N_DIGITS-1:0] an_nxt;
    logic [3:0]          code_nxt;

    logic [3:0]          code_mem [N_DIGITS];
    logic [N_DIGITS-1:0] blank_q;

    // Digit storage; out-of-range addresses are dropped silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                code_mem[i] <= 4'd0;
            end
            blank_q <= '1;
        end else if (wr_en && (32'(wr_addr) < N_DIGITS)) begin
            code_mem[wr_addr] <= wr_data;
            blank_q[wr_addr]  <= wr_blank;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = scan_idx;
        tick_nxt  = 1'b0;
        if (!en) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_GUARD;
                    cnt_nxt   = '0;
                end
                S_GUARD: begin
                    if (cnt == CW'(GUARD - 1)) begin
                        state_nxt = S_ON;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_ON: begin
                    if (cnt == CW'(DIV - 1)) begin
                        state_nxt = S_GUARD;
                        cnt_nxt   = '0;
                        if (scan_idx == AW'(N_DIGITS - 1)) begin
                            idx_nxt  = '0;
                            tick_nxt = 1'b1;
                        end else begin
                            idx_nxt = scan_idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are precomputed from next-state so they are registered yet aligned with the state.
    // Storage is read before this edge's write, so a write shows up one cycle after its edge.
    always_comb begin
        an_nxt   = '1;
        code_nxt = 4'd0;
        if (state_nxt != S_IDLE) begin
            code_nxt = code_mem[idx_nxt];
        end
        if (state_nxt == S_ON && !blank_q[idx_nxt]) begin
            an_nxt[idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            scan_idx   <= '0;
            frame_tick <= 1'b0;
            dig_an     <= '1;
            code_out   <= 4'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            scan_idx   <= idx_nxt;
            frame_tick <= tick_nxt;
            dig_an     <= an_nxt;
            code_out   <= code_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (N_DIGITS=4, DIV=8, GUARD=2) with hand-computed expectations.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_blank;
    logic [3:0] code_out;
    logic [3:0] dig_an;
    logic [1:0] scan_idx;
    logic       frame_tick;

    int n_assert = 0;
    int n_fail   = 0;
    int tick_cnt = 0;

    logic [3:0] an_tab   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] code_tab [4] = '{4'd3, 4'd7, 4'd9, 4'd1};

    seg_scan_ctrl #(.N_DIGITS(4), .DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_blank   (wr_blank),
        .code_out   (code_out),
        .dig_an     (dig_an),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick === 1'b1) tick_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0;
        wr_addr = 2'd0; wr_data = 4'd0; wr_blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", 32'(dig_an), 32'hF);
        chk("rst_code", 32'(code_out), 32'h0);
        chk("rst_idx", 32'(scan_idx), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);

        // Basic scan with reset-default storage (blank=1 would hide digits, so only guard timing
        // and codes are visible; unblank digits 0 and 1 while idle first).
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd0; wr_blank = 1'b0;
        step(1);
        wr_addr = 2'd1;
        step(1);
        wr_en = 1'b0;
        chk("idle_an", 32'(dig_an), 32'hF);
        en = 1'b1;
        step(1);
        chk("t1_g1_an", 32'(dig_an), 32'hF);
        chk("t1_g1_code", 32'(code_out), 32'h0);
        step(1);
        chk("t1_g2_an", 32'(dig_an), 32'hF);
        step(1);
        chk("t1_on1_an", 32'(dig_an), 32'hE);
        chk("t1_on1_code", 32'(code_out), 32'h0);
        step(7);
        chk("t1_on8_an", 32'(dig_an), 32'hE);
        step(1);
        chk("t1_d1g1_an", 32'(dig_an), 32'hF);
        chk("t1_d1g1_idx", 32'(scan_idx), 32'h1);
        step(1);
        chk("t1_d1g2_an", 32'(dig_an), 32'hF);
        step(1);
        chk("t1_d1on_an", 32'(dig_an), 32'hD);
        chk("t1_d1on_code", 32'(code_out), 32'h0);
        en = 1'b0;
        step(1);
        chk("t1_off_an", 32'(dig_an), 32'hF);
        chk("t1_off_idx", 32'(scan_idx), 32'h0);

        // Load codes 3,7,9,1 and scan one full frame.
        for (int a = 0; a < 4; a++) begin
            wr_en = 1'b1; wr_addr = 2'(a); wr_data = code_tab[a]; wr_blank = 1'b0;
            step(1);
        end
        wr_en = 1'b0;
        tick_cnt = 0;
        en = 1'b1;
        step(1);
        chk("t2_first_tick", 32'(frame_tick), 32'h0);
        for (int d = 0; d < 4; d++) begin
            step(2);
            chk($sformatf("t2_on1_an_d%0d", d), 32'(dig_an), 32'(an_tab[d]));
            chk($sformatf("t2_on1_code_d%0d", d), 32'(code_out), 32'(code_tab[d]));
            chk($sformatf("t2_on1_idx_d%0d", d), 32'(scan_idx), 32'(d));
            step(7);
            chk($sformatf("t2_on8_an_d%0d", d), 32'(dig_an), 32'(an_tab[d]));
            step(1);
        end
        chk("t2_wrap_tick", 32'(frame_tick), 32'h1);
        chk("t2_wrap_idx", 32'(scan_idx), 32'h0);
        chk("t2_tick_cnt", 32'(tick_cnt), 32'h1);
        step(1);
        chk("t2_tick_clr", 32'(frame_tick), 32'h0);

        // Blank digit 2; mid-ON rewrite of active digit 1; write to digit 3 while 1 is lit.
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd9; wr_blank = 1'b1;
        step(1);
        wr_en = 1'b0;
        chk("t3_d0_an", 32'(dig_an), 32'hE);
        step(7);
        step(3);
        chk("t4_d1on1_an", 32'(dig_an), 32'hD);
        chk("t4_d1on1_code", 32'(code_out), 32'h7);
        step(2);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd5; wr_blank = 1'b0;
        step(1);
        wr_en = 1'b0;
        chk("t4_wr_edge_code", 32'(code_out), 32'h7);
        step(1);
        chk("t4_wr_next_code", 32'(code_out), 32'h5);
        chk("t4_wr_next_an", 32'(dig_an), 32'hD);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'd6; wr_blank = 1'b0;
        step(1);
        wr_en = 1'b0;
        step(1);
        chk("t4_other_code", 32'(code_out), 32'h5);
        chk("t4_other_an", 32'(dig_an), 32'hD);
        step(1);
        step(3);
        chk("t3_blank_an", 32'(dig_an), 32'hF);
        chk("t3_blank_idx", 32'(scan_idx), 32'h2);
        chk("t3_blank_code", 32'(code_out), 32'h9);
        step(7);
        chk("t3_blank_on8_an", 32'(dig_an), 32'hF);
        step(3);
        chk("t4_d3_an", 32'(dig_an), 32'h7);
        chk("t4_d3_code", 32'(code_out), 32'h6);
        chk("t4_d3_idx", 32'(scan_idx), 32'h3);
        step(7);
        step(1);
        chk("t4_wrap_tick", 32'(frame_tick), 32'h1);

        // Unblank digit 2, then drop en in the middle of its ON slot.
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd9; wr_blank = 1'b0;
        step(1);
        wr_en = 1'b0;
        step(1);
        chk("t5_d0_code", 32'(code_out), 32'h3);
        step(7);
        step(10);
        chk("t5_d1_code", 32'(code_out), 32'h5);
        step(3);
        chk("t5_d2_an", 32'(dig_an), 32'hB);
        chk("t5_d2_code", 32'(code_out), 32'h9);
        step(2);
        tick_cnt = 0;
        en = 1'b0;
        step(1);
        chk("t5_off_an", 32'(dig_an), 32'hF);
        chk("t5_off_idx", 32'(scan_idx), 32'h0);
        chk("t5_off_code", 32'(code_out), 32'h0);
        chk("t5_off_tick", 32'(frame_tick), 32'h0);
        step(3);
        chk("t5_idle_tick_cnt", 32'(tick_cnt), 32'h0);
        chk("t5_idle_an", 32'(dig_an), 32'hF);
        en = 1'b1;
        step(1);
        chk("t5_re_g1_an", 32'(dig_an), 32'hF);
        chk("t5_re_g1_idx", 32'(scan_idx), 32'h0);
        step(2);
        chk("t5_re_on_an", 32'(dig_an), 32'hE);
        chk("t5_re_on_code", 32'(code_out), 32'h3);

        // Asynchronous reset in the middle of a guard interval.
        step(8);
        chk("t6_guard_idx", 32'(scan_idx), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_an", 32'(dig_an), 32'hF);
        chk("t6_async_code", 32'(code_out), 32'h0);
        chk("t6_async_idx", 32'(scan_idx), 32'h0);
        chk("t6_async_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        chk("t6_g1_an", 32'(dig_an), 32'hF);
        step(2);
        chk("t6_d0_an", 32'(dig_an), 32'hF);
        chk("t6_d0_code", 32'(code_out), 32'h0);
        chk("t6_d0_idx", 32'(scan_idx), 32'h0);
        step(10);
        chk("t6_d1_an", 32'(dig_an), 32'hF);
        chk("t6_d1_code", 32'(code_out), 32'h0);
        chk("t6_d1_idx", 32'(scan_idx), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
